// File: rtl/i3c_dat_mem_arbiter_if.sv
// rtl/i3c_dat_mem_arbiter_if.sv - sw/hw requester ports and DAT RAM port of the arbiter
// slave: arbiter side; master: requesters plus RAM side.
interface i3c_dat_mem_arbiter_if #(
  parameter int AddrWidth = 8,
  parameter int DataWidth = 64
);
  logic                 sw_req;
  logic                 sw_write;
  logic [AddrWidth-1:0] sw_addr;
  logic [DataWidth-1:0] sw_wdata;
  logic [DataWidth-1:0] sw_wmask;
  logic                 sw_gnt;
  logic                 sw_rvalid;
  logic [DataWidth-1:0] sw_rdata;

  logic                 hw_req;
  logic                 hw_lock;
  logic                 hw_write;
  logic [AddrWidth-1:0] hw_addr;
  logic [DataWidth-1:0] hw_wdata;
  logic [DataWidth-1:0] hw_wmask;
  logic                 hw_gnt;
  logic                 hw_rvalid;
  logic [DataWidth-1:0] hw_rdata;

  logic                 mem_req;
  logic                 mem_write;
  logic [AddrWidth-1:0] mem_addr;
  logic [DataWidth-1:0] mem_wdata;
  logic [DataWidth-1:0] mem_wmask;
  logic [DataWidth-1:0] mem_rdata;
  logic                 mem_rvalid;

  modport slave (
    input  sw_req, sw_write, sw_addr, sw_wdata, sw_wmask,
    output sw_gnt, sw_rvalid, sw_rdata,
    input  hw_req, hw_lock, hw_write, hw_addr, hw_wdata, hw_wmask,
    output hw_gnt, hw_rvalid, hw_rdata,
    output mem_req, mem_write, mem_addr, mem_wdata, mem_wmask,
    input  mem_rdata, mem_rvalid
  );

  modport master (
    output sw_req, sw_write, sw_addr, sw_wdata, sw_wmask,
    input  sw_gnt, sw_rvalid, sw_rdata,
    output hw_req, hw_lock, hw_write, hw_addr, hw_wdata, hw_wmask,
    input  hw_gnt, hw_rvalid, hw_rdata,
    input  mem_req, mem_write, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata, mem_rvalid
  );
endinterface

// File: rtl/i3c_dat_mem_arbiter.sv
// rtl/i3c_dat_mem_arbiter.sv - single-port DAT RAM arbiter, hw priority, read-response routing
// Optional sw starvation guard: define I3C_DAT_ARB_STARVE_GUARD_EN.
module i3c_dat_mem_arbiter #(
  parameter int AddrWidth = 8,
  parameter int DataWidth = 64,
  parameter int MaxWait   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  i3c_dat_mem_arbiter_if.slave   bus,
  output logic                   err_o
);

  typedef enum logic [0:0] {ARB, HW_LOCKED} state_e;

  state_e state;
  logic   sw_gnt;
  logic   hw_gnt;
  logic   sw_force;
  logic   tag_valid;
  logic   tag_hw;
  logic   mem_write;
  logic   sw_rvalid;
  logic   hw_rvalid;

`ifdef I3C_DAT_ARB_STARVE_GUARD_EN
  localparam int CntW = $clog2(MaxWait + 1);
  logic [CntW-1:0] wait_cnt;

  assign sw_force = (state == ARB) && (wait_cnt == CntW'(MaxWait));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt <= '0;
    end else if (sw_gnt || (state == ARB && !bus.sw_req)) begin
      wait_cnt <= '0;
    end else if (state == ARB && wait_cnt != CntW'(MaxWait)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic unused_max_wait;
  assign unused_max_wait = (MaxWait > 0);
  assign sw_force        = 1'b0;
`endif

  // Grants are gated by reset so every output reads 0 while rst_ni is low.
  always_comb begin
    sw_gnt = 1'b0;
    hw_gnt = 1'b0;
    if (rst_ni) begin
      if (state == HW_LOCKED) begin
        hw_gnt = bus.hw_req;
        sw_gnt = bus.sw_req & ~bus.hw_req & ~bus.hw_lock;
      end else if (sw_force) begin
        sw_gnt = bus.sw_req;
        hw_gnt = bus.hw_req & ~bus.sw_req;
      end else begin
        hw_gnt = bus.hw_req;
        sw_gnt = bus.sw_req & ~bus.hw_req;
      end
    end
  end

  assign bus.sw_gnt = sw_gnt;
  assign bus.hw_gnt = hw_gnt;
  assign mem_write  = hw_gnt ? bus.hw_write : (sw_gnt ? bus.sw_write : 1'b0);

  assign bus.mem_req   = sw_gnt | hw_gnt;
  assign bus.mem_write = mem_write;
  assign bus.mem_addr  = hw_gnt ? bus.hw_addr  : (sw_gnt ? bus.sw_addr  : '0);
  assign bus.mem_wdata = hw_gnt ? bus.hw_wdata : (sw_gnt ? bus.sw_wdata : '0);
  assign bus.mem_wmask = hw_gnt ? bus.hw_wmask : (sw_gnt ? bus.sw_wmask : '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ARB;
      tag_valid <= 1'b0;
      tag_hw    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      case (state)
        ARB:       if (hw_gnt && bus.hw_lock) state <= HW_LOCKED;
        HW_LOCKED: if (!bus.hw_lock) state <= ARB;
        default:   state <= ARB;
      endcase
      // RAM answers exactly one cycle after a read, so the tag only lives one cycle.
      tag_valid <= (sw_gnt | hw_gnt) & ~mem_write;
      tag_hw    <= hw_gnt;
      if (bus.mem_rvalid && !tag_valid) err_o <= 1'b1;
    end
  end

  assign sw_rvalid     = bus.mem_rvalid & tag_valid & ~tag_hw;
  assign hw_rvalid     = bus.mem_rvalid & tag_valid & tag_hw;
  assign bus.sw_rvalid = sw_rvalid;
  assign bus.hw_rvalid = hw_rvalid;
  assign bus.sw_rdata  = sw_rvalid ? bus.mem_rdata : '0;
  assign bus.hw_rdata  = hw_rvalid ? bus.mem_rdata : '0;

endmodule

// File: doc/i3c_dat_mem_arbiter.md
Name: i3c_dat_mem_arbiter

Overview:
- Shares the single-port 64-bit DAT memory macro between two requesters:
  - sw: the CSR/register-interface DAT window.
  - hw: the controller command FSM doing address lookups and read-modify-writes.
- Sits between the i3c core's DAT export interface and the DAT RAM instance.
- Fixed priority to hw, with optional starvation protection for sw.
- Routes each read response back to the port that issued the read.

Parameters:
- AddrWidth, i3c_pkg::DatAw, DAT word address width.
- DataWidth, 64, RAM word width; mask width equals DataWidth.
- MaxWait, 8, consecutive sw-denied cycles before a forced sw grant (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- sw_req_i  in  1  sw access request
- sw_write_i  in  1  1=write, 0=read
- sw_addr_i  in  AddrWidth  sw word address
- sw_wdata_i  in  DataWidth  sw write data
- sw_wmask_i  in  DataWidth  sw bit write mask
- sw_gnt_o  out  1  sw request accepted this cycle
- sw_rvalid_o  out  1  sw read data valid
- sw_rdata_o  out  DataWidth  sw read data
- hw_req_i  in  1  hw access request
- hw_lock_i  in  1  hw holds the memory after its current grant
- hw_write_i  in  1  1=write, 0=read
- hw_addr_i  in  AddrWidth  hw word address
- hw_wdata_i  in  DataWidth  hw write data
- hw_wmask_i  in  DataWidth  hw bit write mask
- hw_gnt_o  out  1  hw request accepted this cycle
- hw_rvalid_o  out  1  hw read data valid
- hw_rdata_o  out  DataWidth  hw read data
- mem_req_o  out  1  RAM request
- mem_write_o  out  1  RAM write enable
- mem_addr_o  out  AddrWidth  RAM address
- mem_wdata_o  out  DataWidth  RAM write data
- mem_wmask_o  out  DataWidth  RAM write mask
- mem_rdata_i  in  DataWidth  RAM read data
- mem_rvalid_i  in  1  RAM read data valid; one cycle after a read request
- err_o  out  1  sticky: unexpected mem_rvalid_i

Behaviour:
- Clock and reset:
  - Single clock clk_i.
  - Reset rst_ni is asynchronous, active-low.
  - All flops reset.
  - In reset: every output is 0 and state = ARB.
- Grant:
  - Combinational, same cycle as the request.
  - A transfer occurs when req && gnt; a requester must hold req and its fields stable until granted.
  - At most one gnt per cycle.
  - mem_req_o = sw_gnt_o | hw_gnt_o.
  - mem_* fields are muxed from the granted port; all fields are 0 when neither port is granted.
- State machine:
  - ARB:
    - hw_req_i wins over sw_req_i.
    - On an hw grant with hw_lock_i=1, go to HW_LOCKED.
  - HW_LOCKED:
    - sw_gnt_o=0.
    - hw is granted whenever hw_req_i=1.
    - Return to ARB on the first cycle with hw_lock_i=0; the sw grant can occur in that same cycle if hw_req_i=0.
    - Lock deasserting together with an hw request: hw is granted and the state returns to ARB.
- Read tag:
  - A flop captures {valid, owner} on every granted read; writes leave valid=0.
  - In the cycle mem_rvalid_i=1 with tag valid, the owner's rvalid_o=1 and its rdata_o=mem_rdata_i.
  - The other port's rvalid_o=0 and rdata_o=0.
  - Back-to-back reads from alternating owners must route correctly with no bubble.
- Error:
  - mem_rvalid_i=1 with tag invalid sets err_o; the data is dropped.
  - err_o clears only on reset.
- Writes produce no response; the RAM commits them at the clock edge of the grant cycle.
- Reset mid-operation:
  - The tag and lock are discarded.
  - A read issued before reset produces no rvalid after reset.

Optional Feature:
- Macro: I3C_DAT_ARB_STARVE_GUARD_EN.
- Enabled:
  - A wait counter of width $clog2(MaxWait+1) increments each cycle in ARB where sw_req_i=1 and sw_gnt_o=0.
  - It saturates at MaxWait and clears on an sw grant or when sw_req_i=0.
  - When the counter equals MaxWait in ARB, sw wins over hw for one grant, then the counter clears.
  - HW_LOCKED is never overridden, and the counter holds while locked.
- Disabled:
  - No counter; pure hw-over-sw priority.
  - sw can starve indefinitely.

Test Plan:
- Reset sw read: sw read of addr 5 (RAM holds 0x1122334455667788), hw idle → sw_gnt_o=1 in cycle 0; sw_rvalid_o=1 with sw_rdata_o=0x1122334455667788 in cycle 1; hw_rvalid_o=0.
- Simultaneous requests: sw and hw both request reads in the same cycle → hw granted first, sw granted the next cycle; hw_rvalid_o then sw_rvalid_o on consecutive cycles, each carrying data from its own address.
- Lock across RMW: hw read addr 3 with hw_lock_i=1, sw_req_i held → sw_gnt_o stays 0 through the hw read and the following masked write (wmask=0x00000000FFFFFFFF). After lock drops, sw is granted and sw read of addr 3 returns the upper 32 bits unchanged.
- Starvation (feature enabled, MaxWait=8): hw_req_i and sw_req_i held continuously → sw_gnt_o=1 on cycle 8, then hw regains the grant. Feature disabled: sw_gnt_o=0 for 100 cycles.
- Spurious response: mem_rvalid_i forced high with no read outstanding → err_o=1 next cycle and stays 1; both rvalid outputs stay 0.
- Reset mid-read: rst_ni asserted the cycle after an sw read grant → sw_rvalid_o=0 and all outputs 0 during reset; no rvalid after release.
